// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular word queue that drains one word at a time into a uart transmitter.
// Optional drop counter (drop_cnt port) is built when UART_TXQ_DROP_CNT_EN is defined.
`timescale 1ns/1ps
module uart_tx_queue #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WORD_SIZE-1:0]   in_data,
    output logic                   in_ready,
    input  logic                   tx_ready,
    output logic                   send_valid,
    output logic [WORD_SIZE-1:0]   data_bits_tx,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    output logic [7:0]             drop_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    state_t               r_state;
    logic                 r_send_valid;
    logic [WORD_SIZE-1:0] r_data;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Full/empty come from the registered level only, so a pop never frees a slot in the same cycle
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && tx_ready;

    assign in_ready     = !w_full;
    assign empty        = w_empty;
    assign level        = r_level;
    assign send_valid   = r_send_valid;
    assign data_bits_tx = r_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_send_valid <= 1'b0;
            r_data       <= '0;
        end else begin
            r_send_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_data       <= r_mem[r_rd_ptr];
                        r_send_valid <= 1'b1;
                        r_state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (in_valid && w_full && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench; a bit-serial uart model loops words back for comparison.
`timescale 1ns/1ps
module tb_uart_tx_queue;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx_ready;
    logic       send_valid;
    logic [7:0] data_bits_tx;
    logic [4:0] level;
    logic       empty;
`ifdef UART_TXQ_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    uart_tx_queue #(.WORD_SIZE(8), .DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .tx_ready     (tx_ready),
        .send_valid   (send_valid),
        .data_bits_tx (data_bits_tx),
        .level        (level),
        .empty        (empty)
`ifdef UART_TXQ_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0] sb[$];

    // uart model: start bit, 8 data bits LSB first, stop bit, one bit per clock
    logic       hold;
    logic [3:0] u_cnt;
    logic [9:0] u_sh;
    logic       line;
    assign tx_ready = (u_cnt == 4'd0) && !hold;

    always @(posedge clk) begin
        if (rst) begin
            u_cnt <= 4'd0;
            line  <= 1'b1;
        end else if (u_cnt == 4'd0) begin
            line <= 1'b1;
            if (send_valid) begin
                u_sh  <= {1'b1, data_bits_tx, 1'b0};
                u_cnt <= 4'd10;
            end
        end else begin
            line  <= u_sh[0];
            u_sh  <= u_sh >> 1;
            u_cnt <= u_cnt - 4'd1;
        end
    end

    logic       rx_act;
    int         rx_n;
    logic [7:0] rx_sh;
    int         n_rx = 0;
    logic [7:0] exp_w;

    always @(posedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
            rx_n   = 0;
        end else if (!rx_act) begin
            if (line == 1'b0) begin
                rx_act = 1'b1;
                rx_n   = 0;
            end
        end else if (rx_n < 8) begin
            rx_sh = {line, rx_sh[7:1]};
            rx_n++;
        end else begin
            rx_act = 1'b0;
            n_rx++;
            check_eq("rx_stop_bit", line, 1'b1);
            check_eq("rx_sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check_eq("rx_data", rx_sh, exp_w);
            end
        end
    end

    int   n_sv = 0;
    logic prev_sv = 1'b0;

    always @(negedge clk) begin
        if (!rst && send_valid) begin
            n_sv++;
            check_eq("sv_while_tx_ready", tx_ready, 1'b1);
            check_eq("sv_single_cycle", prev_sv, 1'b0);
        end
        prev_sv = send_valid;
    end

    task automatic push(input logic [7:0] d, input logic exp_acc);
        in_valid = 1'b1;
        in_data  = d;
        check_eq("in_ready", in_ready, exp_acc);
        if (exp_acc) sb.push_back(d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((sb.size() != 0 || rx_act || !tx_ready || !empty) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_in_time", n < max_cyc, 1'b1);
        check_eq("drain_level", level, 5'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] burst [10];
    int sv0;
    int rx0;
    int k;

    initial begin
        burst = '{8'h55, 8'hA3, 8'h7E, 8'h00, 8'hFF, 8'hC3, 8'h3C, 8'h5A, 8'h81, 8'h1E};
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; hold = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_send_valid", send_valid, 1'b0);
        check_eq("rst_level", level, 5'd0);
        check_eq("rst_empty", empty, 1'b1);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_data", data_bits_tx, 8'h00);
`ifdef UART_TXQ_DROP_CNT_EN
        check_eq("rst_drop_cnt", drop_cnt, 8'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single word latency
        sv0 = n_sv; rx0 = n_rx;
        push(8'hA1, 1'b1);
        check_eq("t1_level_after_push", level, 5'd1);
        check_eq("t1_no_early_sv", send_valid, 1'b0);
        @(negedge clk);
        check_eq("t1_sv", send_valid, 1'b1);
        check_eq("t1_data", data_bits_tx, 8'hA1);
        check_eq("t1_level_after_pop", level, 5'd0);
        @(negedge clk);
        check_eq("t1_sv_drop", send_valid, 1'b0);
        wait_drain(100);
        check_eq("t1_pulses", n_sv - sv0, 1);
        check_eq("t1_rx_count", n_rx - rx0, 1);

        // burst of ten
        sv0 = n_sv; rx0 = n_rx;
        for (int i = 0; i < 10; i++) push(burst[i], 1'b1);
        wait_drain(400);
        check_eq("t2_pulses", n_sv - sv0, 10);
        check_eq("t2_rx_count", n_rx - rx0, 10);

        // fill to full with the uart held busy, 17th word dropped
        hold = 1'b1;
        sv0 = n_sv; rx0 = n_rx;
        for (int i = 0; i < 16; i++) push(8'(i * 17 + 3), 1'b1);
        check_eq("t3_level_full", level, 5'd16);
        check_eq("t3_not_empty", empty, 1'b0);
        push(8'hEE, 1'b0);
        check_eq("t3_level_after_drop", level, 5'd16);
`ifdef UART_TXQ_DROP_CNT_EN
        check_eq("t3_drop_cnt", drop_cnt, 8'd1);
`endif
        hold = 1'b0;
        wait_drain(600);
        check_eq("t3_pulses", n_sv - sv0, 16);
        check_eq("t3_rx_count", n_rx - rx0, 16);

        // full queue: push during the pop cycle is refused, next cycle accepted
        hold = 1'b1;
        sv0 = n_sv;
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i), 1'b1);
        check_eq("t4_level_full", level, 5'd16);
        hold = 1'b0;
        push(8'h99, 1'b0);
        check_eq("t4_level_after_pop", level, 5'd15);
        push(8'h99, 1'b1);
        check_eq("t4_level_refilled", level, 5'd16);
`ifdef UART_TXQ_DROP_CNT_EN
        check_eq("t4_drop_cnt", drop_cnt, 8'd2);
`endif
        wait_drain(600);
        check_eq("t4_pulses", n_sv - sv0, 17);

        // uart stays busy: word waits in the queue
        hold = 1'b1;
        sv0 = n_sv;
        push(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("t6_no_sv", n_sv - sv0, 0);
        check_eq("t6_level_hold", level, 5'd1);
        check_eq("t6_not_empty", empty, 1'b0);
        hold = 1'b0;
        wait_drain(100);
        check_eq("t6_pulses", n_sv - sv0, 1);

        // reset while waiting for the uart to go busy
        hold = 1'b1;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), 1'b1);
        check_eq("t5_level_six", level, 5'd6);
        hold = 1'b0;
        k = 0;
        while (!send_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("t5_sv_seen", send_valid, 1'b1);
        @(negedge clk);
        check_eq("t5_level_five", level, 5'd5);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_level", level, 5'd0);
        check_eq("t5_rst_sv", send_valid, 1'b0);
        check_eq("t5_rst_empty", empty, 1'b1);
        check_eq("t5_rst_in_ready", in_ready, 1'b1);
        check_eq("t5_rst_data", data_bits_tx, 8'h00);
`ifdef UART_TXQ_DROP_CNT_EN
        check_eq("t5_rst_drop_cnt", drop_cnt, 8'd0);
`endif
        rst = 1'b0;
        sb.delete();
        sv0 = n_sv;
        repeat (30) @(negedge clk);
        check_eq("t5_no_sv_after_rst", n_sv - sv0, 0);
        check_eq("t5_level_stays_zero", level, 5'd0);
        push(8'h5C, 1'b1);
        wait_drain(100);
        check_eq("t5_pulses_after_push", n_sv - sv0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
